// File: rtl/ig_stream_grad_pkg.sv
// Shared types and helpers for the streaming image-gradient engine.
package ig_pkg;

    // Frame sequencer states.
    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    // Gradient mode encodings, captured together with start.
    localparam logic MODE_FWD = 1'b0;
    localparam logic MODE_CEN = 1'b1;

    // Pack two gw-bit two's complement components as {gx, gy} in the low
    // 2*gw bits of the result; callers size-cast down to their word width.
    function automatic logic [63:0] pack_grad(input int gw, input logic [31:0] gx, input logic [31:0] gy);
        logic [63:0] mask;
        mask = (64'd1 << gw) - 64'd1;
        return (({32'd0, gx} & mask) << gw) | ({32'd0, gy} & mask);
    endfunction

endpackage

// File: rtl/ig_stream_grad_if.sv
// Control handshake plus image-read and gradient-write bus of the engine.
interface ig_stream_grad_if #(
    parameter int ADDR_W = 16,
    parameter int PIX_W  = 8,
    parameter int G_W    = PIX_W + 2
) ();
    logic                start;
    logic                mode;
    logic                busy;
    logic                done;
    logic                img_rd;
    logic [ADDR_W-1:0]   img_addr;
    logic [PIX_W-1:0]    img_di;
    logic                grad_wr;
    logic [ADDR_W-1:0]   grad_addr;
    logic [2*G_W-1:0]    grad_do;

    // Engine side.
    modport master (
        input  start, mode, img_di,
        output busy, done, img_rd, img_addr, grad_wr, grad_addr, grad_do
    );

    // Sequencer / memory side.
    modport slave (
        output start, mode, img_di,
        input  busy, done, img_rd, img_addr, grad_wr, grad_addr, grad_do
    );
endinterface

// File: rtl/ig_stream_grad_delay_line.sv
// Pixel delay line spanning two image rows plus one pixel. Stage 0 is the
// pixel currently arriving on din; stages 1..DEPTH-1 are registers, so the
// neighbourhood of the centre is complete in the same cycle its down
// neighbour arrives.
module ig_delay_line #(
    parameter int W     = 4,
    parameter int DEPTH = 2 * W + 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tap_d,
    output logic [WIDTH-1:0] tap_r,
    output logic [WIDTH-1:0] tap_c,
    output logic [WIDTH-1:0] tap_l,
    output logic [WIDTH-1:0] tap_u
);
    logic [WIDTH-1:0] sr_reg [1:DEPTH-1];

    // Shift the arriving pixel in and every stored pixel one stage deeper.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 1; i < DEPTH; i++) sr_reg[i] <= '0;
        end else if (shift_en) begin
            sr_reg[1] <= din;
            for (int i = 2; i < DEPTH; i++) sr_reg[i] <= sr_reg[i-1];
        end
    end

    assign tap_d = din;
    assign tap_r = sr_reg[W-1];
    assign tap_c = sr_reg[W];
    assign tap_l = sr_reg[W+1];
    assign tap_u = sr_reg[2*W];
endmodule

// File: rtl/ig_stream_grad.sv
// Streaming image-gradient engine: reads a raster image once, forms
// clamped forward or central differences and writes {gx, gy} per pixel.
module ig_stream_grad
    import ig_pkg::*;
#(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int PIX_W  = 8,
    parameter int ADDR_W = 16,
    parameter int G_W    = PIX_W + 2
) (
    input  logic          clk,
    input  logic          reset,
    ig_stream_grad_if.master bus
);
    localparam int N = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] W_CNT     = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] X_LAST    = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] Y_LAST    = ADDR_W'(IMG_H - 1);

    state_t              state_reg;
    logic                mode_reg;
    logic                busy_reg;
    logic                done_reg;
    logic                img_rd_reg;
    logic [ADDR_W-1:0]   img_addr_reg;
    logic [ADDR_W-1:0]   drain_cnt_reg;
    logic                rd_dly_reg;
    logic [ADDR_W-1:0]   fill_reg;
    logic [ADDR_W-1:0]   cx_reg;
    logic [ADDR_W-1:0]   cy_reg;
    logic [ADDR_W-1:0]   cen_addr_reg;
    logic                grad_wr_reg;
    logic [ADDR_W-1:0]   grad_addr_reg;
    logic [2*G_W-1:0]    grad_do_reg;

    logic [PIX_W-1:0] d_raw, r_raw, c_pix, l_raw, u_raw;
    logic [PIX_W-1:0] d_pix, r_pix, l_pix, u_pix;
    logic [PIX_W-1:0] gx_sub, gy_sub;
    logic [G_W-1:0]   gx, gy;
    logic [2*G_W-1:0] grad_do_next;
    logic             start_accept;
    logic             shift_en;
    logic             emit;

    assign start_accept = (state_reg == IDLE) && bus.start;
    // Read data trails the read strobe by one cycle; DRAIN keeps the line
    // moving so the last row reaches the centre tap.
    assign shift_en     = rd_dly_reg || (state_reg == DRAIN);
    // Once the line holds IMG_W pixels beyond the centre, every shift
    // presents a complete neighbourhood for the next raster index.
    assign emit         = shift_en && (fill_reg == W_CNT);

    ig_delay_line #(
        .W     (IMG_W),
        .DEPTH (2 * IMG_W + 1),
        .WIDTH (PIX_W)
    ) u_line (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .din      (bus.img_di),
        .tap_d    (d_raw),
        .tap_r    (r_raw),
        .tap_c    (c_pix),
        .tap_l    (l_raw),
        .tap_u    (u_raw)
    );

    // Edge clamping replaces missing neighbours with the centre pixel.
    assign l_pix = (cx_reg == '0)     ? c_pix : l_raw;
    assign r_pix = (cx_reg == X_LAST) ? c_pix : r_raw;
    assign u_pix = (cy_reg == '0)     ? c_pix : u_raw;
    assign d_pix = (cy_reg == Y_LAST) ? c_pix : d_raw;

    assign gx_sub = (mode_reg == MODE_CEN) ? l_pix : c_pix;
    assign gy_sub = (mode_reg == MODE_CEN) ? u_pix : c_pix;

    // Zero-extended subtraction is exact because G_W > PIX_W.
    assign gx = {{(G_W-PIX_W){1'b0}}, r_pix} - {{(G_W-PIX_W){1'b0}}, gx_sub};
    assign gy = {{(G_W-PIX_W){1'b0}}, d_pix} - {{(G_W-PIX_W){1'b0}}, gy_sub};

    assign grad_do_next = (2*G_W)'(pack_grad(G_W, 32'($signed(gx)), 32'($signed(gy))));

    // Frame sequencer with registered handshake and read-side outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            mode_reg      <= MODE_FWD;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            img_rd_reg    <= 1'b0;
            img_addr_reg  <= '0;
            drain_cnt_reg <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        state_reg    <= READ;
                        mode_reg     <= bus.mode;
                        busy_reg     <= 1'b1;
                        img_rd_reg   <= 1'b1;
                        img_addr_reg <= '0;
                    end
                end
                READ: begin
                    if (img_addr_reg == LAST_ADDR) begin
                        state_reg     <= DRAIN;
                        img_rd_reg    <= 1'b0;
                        drain_cnt_reg <= '0;
                    end else begin
                        img_addr_reg <= img_addr_reg + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt_reg == W_CNT) state_reg <= DONE;
                    else drain_cnt_reg <= drain_cnt_reg + 1'b1;
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Fill tracking, centre coordinates and the registered gradient write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_dly_reg    <= 1'b0;
            fill_reg      <= '0;
            cx_reg        <= '0;
            cy_reg        <= '0;
            cen_addr_reg  <= '0;
            grad_wr_reg   <= 1'b0;
            grad_addr_reg <= '0;
            grad_do_reg   <= '0;
        end else begin
            rd_dly_reg  <= img_rd_reg;
            grad_wr_reg <= emit;
            if (start_accept) begin
                fill_reg     <= '0;
                cx_reg       <= '0;
                cy_reg       <= '0;
                cen_addr_reg <= '0;
            end else begin
                if (shift_en && (fill_reg != W_CNT)) fill_reg <= fill_reg + 1'b1;
                if (emit) begin
                    cen_addr_reg <= cen_addr_reg + 1'b1;
                    if (cx_reg == X_LAST) begin
                        cx_reg <= '0;
                        cy_reg <= (cy_reg == Y_LAST) ? '0 : cy_reg + 1'b1;
                    end else begin
                        cx_reg <= cx_reg + 1'b1;
                    end
                end
            end
            if (emit) begin
                grad_addr_reg <= cen_addr_reg;
                grad_do_reg   <= grad_do_next;
            end
        end
    end

    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.img_rd    = img_rd_reg;
    assign bus.img_addr  = img_addr_reg;
    assign bus.grad_wr   = grad_wr_reg;
    assign bus.grad_addr = grad_addr_reg;
    assign bus.grad_do   = grad_do_reg;
endmodule

// File: tb/tb_ig_stream_grad.sv
// Directed bench for ig_stream_grad: a 4x3 instance for the hand-checked
// scenarios and a default 256x256 instance against a reference model.
module tb_ig_stream_grad;
    import ig_pkg::*;

    localparam int SW = 4;
    localparam int SH = 3;
    localparam int BW = 256;
    localparam int BH = 256;
    localparam int BN = BW * BH;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    logic [7:0] img_s [0:15];
    logic [7:0] img_b [0:BN-1];

    ig_stream_grad_if #(.ADDR_W(16), .PIX_W(8), .G_W(10)) s_if ();
    ig_stream_grad_if #(.ADDR_W(16), .PIX_W(8), .G_W(10)) b_if ();

    ig_stream_grad #(.IMG_W(SW), .IMG_H(SH), .PIX_W(8), .ADDR_W(16), .G_W(10)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (s_if.master)
    );

    ig_stream_grad dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Image memories with one-cycle registered read.
    always @(posedge clk) if (s_if.img_rd) s_if.img_di <= img_s[s_if.img_addr[3:0]];
    always @(posedge clk) if (b_if.img_rd) b_if.img_di <= img_b[b_if.img_addr];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Hand-derived words for the 4x3 scenarios (kind 0 ramp fwd, 1 ramp cen, 2 extremes).
    function automatic logic [19:0] exp_word(input int kind, input int idx);
        int x, y, gx, gy;
        x = idx % SW;
        y = idx / SW;
        case (kind)
            0: begin gx = (x == 3) ? 0 : 1;              gy = (y == 2) ? 0 : 16; end
            1: begin gx = (x == 0 || x == 3) ? 1 : 2;    gy = (y == 1) ? 32 : 16; end
            default: begin gx = (idx == 0) ? -255 : 0;  gy = (idx == 0) ? -255 : 0; end
        endcase
        return {10'(gx), 10'(gy)};
    endfunction

    function automatic int pb(input int x, input int y);
        return int'(img_b[16'(y * BW + x)]);
    endfunction

    // Reference: clamped neighbourhood taken straight from the 2-D image.
    function automatic logic [19:0] ref_word(input int idx, input logic m);
        int x, y, c, l, r, u, d, gx, gy;
        x = idx % BW;
        y = idx / BW;
        c = pb(x, y);
        l = (x == 0)      ? c : pb(x - 1, y);
        r = (x == BW - 1) ? c : pb(x + 1, y);
        u = (y == 0)      ? c : pb(x, y - 1);
        d = (y == BH - 1) ? c : pb(x, y + 1);
        gx = m ? (r - l) : (r - c);
        gy = m ? (d - u) : (d - c);
        return {10'(gx), 10'(gy)};
    endfunction

    task automatic fill_ramp();
        for (int i = 0; i < 16; i++) img_s[i] = 8'((i / SW) * 16 + (i % SW));
    endtask

    // Start edge, then return at the negedge inside cycle 0.
    task automatic launch_small(input logic m, input bit hold);
        @(negedge clk);
        s_if.mode  = m;
        s_if.start = 1'b1;
        @(negedge clk);
        if (!hold) s_if.start = 1'b0;
    endtask

    // Follows one 4x3 frame from cycle 0 to done; returns at the done negedge.
    task automatic collect_small(input string tag, input int kind, input bit pulse_mid);
        int rd_cnt, wr_cnt, done_cyc;
        rd_cnt   = 0;
        wr_cnt   = 0;
        done_cyc = -1;
        check({tag, "/busy_c0"}, 64'(s_if.busy), 64'd1);
        for (int c = 0; c < 60 && done_cyc < 0; c++) begin
            if (s_if.img_rd) begin
                check({tag, "/img_addr"}, 64'(s_if.img_addr), 64'(c));
                rd_cnt++;
            end
            if (s_if.grad_wr) begin
                check({tag, "/wr_cycle"}, 64'(c), 64'(wr_cnt + 6));
                check({tag, "/grad_addr"}, 64'(s_if.grad_addr), 64'(wr_cnt));
                check({tag, "/grad_do"}, 64'(s_if.grad_do), 64'(exp_word(kind, wr_cnt)));
                wr_cnt++;
            end
            if (s_if.done) begin
                done_cyc = c;
                check({tag, "/busy_at_done"}, 64'(s_if.busy), 64'd0);
            end
            if (pulse_mid && c == 3) s_if.start = 1'b1;
            if (pulse_mid && c == 4) s_if.start = 1'b0;
            if (done_cyc < 0) @(negedge clk);
        end
        check({tag, "/done_cycle"}, 64'(done_cyc), 64'd18);
        check({tag, "/rd_count"}, 64'(rd_cnt), 64'd12);
        check({tag, "/wr_count"}, 64'(wr_cnt), 64'd12);
        $display("frame %s: %0d reads, %0d writes, done in cycle %0d", tag, rd_cnt, wr_cnt, done_cyc);
    endtask

    task automatic idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, "/no_wr"}, 64'(s_if.grad_wr), 64'd0);
            check({tag, "/no_rd"}, 64'(s_if.img_rd), 64'd0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "/busy"}, 64'(s_if.busy), 64'd0);
        check({tag, "/done"}, 64'(s_if.done), 64'd0);
        check({tag, "/img_rd"}, 64'(s_if.img_rd), 64'd0);
        check({tag, "/img_addr"}, 64'(s_if.img_addr), 64'd0);
        check({tag, "/grad_wr"}, 64'(s_if.grad_wr), 64'd0);
        check({tag, "/grad_addr"}, 64'(s_if.grad_addr), 64'd0);
        check({tag, "/grad_do"}, 64'(s_if.grad_do), 64'd0);
    endtask

    initial begin
        int rd_cnt, wr_cnt, first_c, done_c;
        n_cmp = 0;
        n_bad = 0;
        s_if.start = 1'b0;
        s_if.mode  = MODE_FWD;
        b_if.start = 1'b0;
        b_if.mode  = MODE_FWD;
        fill_ramp();
        for (int i = 0; i < BN; i++) img_b[i] = 8'($urandom_range(0, 255));

        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Forward ramp, with a start pulse while busy that must be ignored.
        launch_small(MODE_FWD, 1'b0);
        collect_small("fwd", 0, 1'b1);
        idle_check("fwd_after", 6);

        // Central ramp.
        launch_small(MODE_CEN, 1'b0);
        collect_small("cen", 1, 1'b0);
        idle_check("cen_after", 2);

        // Extreme values.
        for (int i = 0; i < 16; i++) img_s[i] = 8'd0;
        img_s[0] = 8'd255;
        launch_small(MODE_FWD, 1'b0);
        collect_small("ext", 2, 1'b0);
        fill_ramp();
        idle_check("ext_after", 2);

        // Start held across done: back-to-back frame with mode re-latched.
        launch_small(MODE_FWD, 1'b1);
        s_if.mode = MODE_CEN;
        collect_small("hold1", 0, 1'b0);
        @(negedge clk);
        s_if.start = 1'b0;
        collect_small("hold2", 1, 1'b0);
        idle_check("hold_after", 3);

        // Reset in cycle 8 aborts the frame; a fresh frame then matches scenario 1.
        launch_small(MODE_FWD, 1'b0);
        repeat (8) @(negedge clk);
        check("rst_pre_grad_wr", 64'(s_if.grad_wr), 64'd1);
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (2) begin
            @(negedge clk);
            check("rst_hold/no_wr", 64'(s_if.grad_wr), 64'd0);
        end
        reset = 1'b1;
        idle_check("rst_release", 4);
        launch_small(MODE_FWD, 1'b0);
        collect_small("post_rst", 0, 1'b0);

        // Default-size frame, central mode, random image.
        rd_cnt  = 0;
        wr_cnt  = 0;
        first_c = -1;
        done_c  = -1;
        @(negedge clk);
        b_if.mode  = MODE_CEN;
        b_if.start = 1'b1;
        @(negedge clk);
        b_if.start = 1'b0;
        for (int c = 0; c < 70000 && done_c < 0; c++) begin
            if (b_if.img_rd) begin
                check("big/img_addr", 64'(b_if.img_addr), 64'(c));
                rd_cnt++;
            end
            if (b_if.grad_wr) begin
                if (first_c < 0) first_c = c;
                check("big/grad_addr", 64'(b_if.grad_addr), 64'(wr_cnt));
                check("big/grad_do", 64'(b_if.grad_do), 64'(ref_word(wr_cnt, MODE_CEN)));
                wr_cnt++;
            end
            if (b_if.done) done_c = c;
            if (done_c < 0) @(negedge clk);
        end
        check("big/first_wr_cycle", 64'(first_c), 64'd258);
        check("big/done_cycle", 64'(done_c), 64'd65794);
        check("big/rd_count", 64'(rd_cnt), 64'd65536);
        check("big/wr_count", 64'(wr_cnt), 64'd65536);
        $display("frame big: %0d reads, %0d writes, first write cycle %0d, done in cycle %0d",
                 rd_cnt, wr_cnt, first_c, done_c);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
